// File: rtl/lsu_ctrl_if.sv
// Core-side request/response channel plus the SRAM port of the load/store controller.
// The controller takes the slave view; the core and SRAM together take the master view.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [3:0]  mem_w_en;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w_en, mem_address, mem_write_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w_en, mem_address, mem_write_data
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller in front of a 64 KiB byte-addressed SRAM.
// IDLE -> ACCESS -> RESP per request; errors are caught at accept and never reach the SRAM.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    lsu_ctrl_if.slave   bus,
    output logic [15:0] ld_cnt,
    output logic [15:0] st_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        rsp_err_q;
    logic [15:0] ld_cnt_q, st_cnt_q, err_cnt_q;

    logic        accept;
    logic [2:0]  req_size;
    logic        funct3_bad;
    logic [16:0] end_addr;
    logic        range_bad;
    logic        req_err;
    logic [31:0] load_data;

    // Request decode: access size and legality, evaluated on the live request.
    always_comb begin
        req_size   = 3'd1;
        funct3_bad = 1'b0;
        case (bus.req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            2'b10:   req_size = 3'd4;
            default: req_size = 3'd1;
        endcase
        if (bus.req_we) begin
            funct3_bad = bus.req_funct3 > 3'b010;
        end else begin
            funct3_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        end
    end

    // Bit 16 of the last byte address set means the access would wrap past the SRAM top.
    assign end_addr  = {1'b0, bus.req_addr[15:0]} + {14'd0, req_size} - 17'd1;
    assign range_bad = (|bus.req_addr[31:16]) || end_addr[16];
    assign req_err   = range_bad || funct3_bad;
    assign accept    = (state_q == StIdle) && bus.req_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.req_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (bus.rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Lane enables exist only during ACCESS of a legal store, so an async reset kills them.
    always_comb begin
        bus.req_ready = (state_q == StIdle) && rst_n;
        bus.rsp_valid = (state_q == StResp);
        bus.mem_w_en  = 4'b0000;
        if ((state_q == StAccess) && we_q && !err_q) begin
            case (funct3_q[1:0])
                2'b00:   bus.mem_w_en = 4'b0001;
                2'b01:   bus.mem_w_en = 4'b0011;
                2'b10:   bus.mem_w_en = 4'b1111;
                default: bus.mem_w_en = 4'b0000;
            endcase
        end
    end

    always_comb begin
        load_data = 32'd0;
        case (funct3_q)
            3'b000:  load_data = {{24{bus.mem_read_data[7]}}, bus.mem_read_data[7:0]};
            3'b001:  load_data = {{16{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
            3'b010:  load_data = bus.mem_read_data;
            3'b100:  load_data = {24'd0, bus.mem_read_data[7:0]};
            3'b101:  load_data = {16'd0, bus.mem_read_data[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // Request capture; write data only follows stores so loads leave the bus untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            err_q    <= 1'b0;
            addr_q   <= 16'd0;
            wdata_q  <= 32'd0;
        end else if (accept) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            err_q    <= req_err;
            addr_q   <= bus.req_addr[15:0];
            if (bus.req_we) begin
                wdata_q <= bus.req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else if (state_q == StAccess) begin
            rdata_q   <= (we_q || err_q) ? 32'd0 : load_data;
            rsp_err_q <= err_q;
        end
    end

    // Exactly one counter moves on the ACCESS -> RESP transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q  <= 16'd0;
            st_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else if (state_q == StAccess) begin
            if (err_q) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (we_q) begin
                if (st_cnt_q != 16'hFFFF) st_cnt_q <= st_cnt_q + 16'd1;
            end else begin
                if (ld_cnt_q != 16'hFFFF) ld_cnt_q <= ld_cnt_q + 16'd1;
            end
        end
    end

    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign ld_cnt             = ld_cnt_q;
    assign st_cnt             = st_cnt_q;
    assign err_cnt            = err_cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array SRAM model, vector table with response scoreboard,
// plus hand sequences for response back-pressure and reset during ACCESS.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] ld_cnt, st_cnt, err_cnt;

    lsu_ctrl_if bus ();

    lsu_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .ld_cnt  (ld_cnt),
        .st_cnt  (st_cnt),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: combinational little-endian read, byte-lane writes at the rising edge.
    logic [7:0]  sram [65536];
    logic [15:0] a0, a1, a2, a3;
    assign a0 = bus.mem_address;
    assign a1 = bus.mem_address + 16'd1;
    assign a2 = bus.mem_address + 16'd2;
    assign a3 = bus.mem_address + 16'd3;
    assign bus.mem_read_data = {sram[a3], sram[a2], sram[a1], sram[a0]};

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                if (bus.mem_w_en[k]) sram[16'(bus.mem_address + 16'(k))] = bus.mem_write_data[8*k +: 8];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  wen;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb_q[$];
    int   n_vec, n_fail;
    int   exp_ld, exp_st, exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnts();
        chk("ld_cnt", {16'd0, ld_cnt}, 32'(exp_ld));
        chk("st_cnt", {16'd0, st_cnt}, 32'(exp_st));
        chk("err_cnt", {16'd0, err_cnt}, 32'(exp_err));
    endtask

    // One request from IDLE through the response handshake; hold > 0 stalls rsp_ready
    // for that many cycles while a stray store is presented.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata_e,
                           input logic err_e, input logic [3:0] wen_e, input int hold);
        rsp_t        e;
        int          waited;
        logic [31:0] held;
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        sb_q.push_back('{rdata: rdata_e, err: err_e});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("access_w_en", {28'd0, bus.mem_w_en}, {28'd0, wen_e});
        chk("access_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("access_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        if (wen_e != 4'b0000) begin
            chk("access_addr", {16'd0, bus.mem_address}, {16'd0, addr[15:0]});
            chk("access_wdata", bus.mem_write_data, wdata);
        end
        @(posedge clk); #1;
        chk("latency2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        waited = 0;
        while (!bus.rsp_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        chk("resp_w_en", {28'd0, bus.mem_w_en}, 32'd0);
        if (err_e) exp_err++;
        else if (we) exp_st++;
        else exp_ld++;
        chk_cnts();
        held = bus.rsp_rdata;
        if (hold > 0) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h0000_0060;
            bus.req_wdata  = 32'hAAAA_5555;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
                chk("hold_rsp_rdata", bus.rsp_rdata, held);
                chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
                chk("hold_w_en", {28'd0, bus.mem_w_en}, 32'd0);
            end
            chk_cnts();
            bus.req_valid = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_fail = 0;
        exp_ld = 0; exp_st = 0; exp_err = 0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_w_en", {28'd0, bus.mem_w_en}, 32'd0);
        chk("rst_addr", {16'd0, bus.mem_address}, 32'd0);
        chk("rst_wdata", bus.mem_write_data, 32'd0);
        chk_cnts();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;

        //            we    f3      addr          wdata         rdata         err   wen
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4'b1111});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 4'b0000});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0021, 32'h0000_00F0, 32'h0000_0000, 1'b0, 4'b0001});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0021, 32'h0000_0000, 32'hFFFF_FFF0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0021, 32'h0000_0000, 32'h0000_00F0, 1'b0, 4'b0000});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0003, 32'h0000_8001, 32'h0000_0000, 1'b0, 4'b0011});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0003, 32'h0000_0000, 32'hFFFF_8001, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0003, 32'h0000_0000, 32'h0000_8001, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_FFFE, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000});
        vecs.push_back('{1'b1, 3'b010, 32'h0001_0000, 32'h1111_2222, 32'h0000_0000, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000});
        vecs.push_back('{1'b1, 3'b100, 32'h0000_0050, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0050, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_FFFF, 32'h0000_1234, 32'h0000_0000, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 3'b110, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000});

        foreach (vecs[i]) begin
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].err, vecs[i].wen, 0);
        end

        // Back-pressure: response held 10 cycles, stray store must not be taken.
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 10);
        run_req(1'b0, 3'b010, 32'h0000_0060, 32'd0, 32'h0000_0000, 1'b0, 4'b0000, 0);

        // Reset during ACCESS of a store: write and response are both dropped.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0040;
        bus.req_wdata  = 32'h1234_5678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstacc_w_en_before", {28'd0, bus.mem_w_en}, 32'hF);
        rst_n = 1'b0;
        #1;
        exp_ld = 0; exp_st = 0; exp_err = 0;
        chk("rstacc_w_en", {28'd0, bus.mem_w_en}, 32'd0);
        chk("rstacc_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstacc_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rstacc_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rstacc_addr", {16'd0, bus.mem_address}, 32'd0);
        chk("rstacc_wdata", bus.mem_write_data, 32'd0);
        chk_cnts();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rstacc_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        run_req(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h0000_0000, 1'b0, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
